// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding word fetcher feeding a
// circular byte buffer that presents a registered 6-byte decode window.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH_BYTES = 16,
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_fetch_req,
    output logic [31:0] o_fetch_addr,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_data,
    output logic [47:0] o_window,
    output logic        o_window_valid,
    output logic [31:0] o_pc,
    input  logic        i_consume,
    input  logic [2:0]  i_consume_len,
    input  logic        i_flush,
    input  logic [31:0] i_flush_addr,
    output logic        o_underflow
);

    localparam int PW = $clog2(DEPTH_BYTES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_e;

    state_e        state_q;
    logic          req_q;
    logic [31:0]   faddr_q, faddr_d;
    logic [31:0]   pc_q, pc_d;
    logic [1:0]    skip_q, skip_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [7:0]    mem_d [DEPTH_BYTES];
    logic [47:0]   win_q, win_d;
    logic          wvalid_q, wvalid_d;
    logic          uf_q, uf_d;

    logic          push;
    logic          cons_ok;
    logic          room;
    logic [2:0]    push_n;

    assign push    = i_fetch_valid && (state_q == WAIT) && !i_flush;
    assign cons_ok = i_consume
                  && (i_consume_len != 3'd0)
                  && (i_consume_len != 3'd7)
                  && (CW'(i_consume_len) <= cnt_q);
    assign room    = (cnt_q + CW'(4)) <= CW'(DEPTH_BYTES);
    // The first word after a redirect carries only the bytes at or above it.
    assign push_n  = 3'd4 - {1'b0, skip_q};

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        skip_d  = skip_q;
        uf_d    = 1'b0;
        win_d   = '0;
        if (i_flush) begin
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            pc_d    = i_flush_addr;
            faddr_d = {i_flush_addr[31:2], 2'b00};
            skip_d  = i_flush_addr[1:0];
        end else begin
            uf_d = i_consume && !cons_ok;
            if (push) begin
                for (int b = 0; b < 4; b++) begin
                    if (2'(b) >= skip_q) begin
                        mem_d[wr_q + PW'(2'(b) - skip_q)] = i_fetch_data[8*b +: 8];
                    end
                end
                wr_d    = wr_q + PW'(push_n);
                faddr_d = faddr_q + 32'd4;
                skip_d  = '0;
            end
            if (cons_ok) begin
                rd_d = rd_q + PW'(i_consume_len);
                pc_d = pc_q + 32'(i_consume_len);
            end
            cnt_d = cnt_q
                  + (push ? CW'(push_n) : CW'(0))
                  - (cons_ok ? CW'(i_consume_len) : CW'(0));
        end
        // Window is built from next-state storage so the output is registered.
        for (int i = 0; i < 6; i++) begin
            if (CW'(i) < cnt_d) begin
                win_d[8*i +: 8] = mem_d[rd_d + PW'(i)];
            end
        end
        wvalid_d = cnt_d >= CW'(6);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
        end else if (i_flush) begin
            req_q <= 1'b0;
            case (state_q)
                WAIT, DROP: state_q <= i_fetch_valid ? IDLE : DROP;
                default:    state_q <= IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (room) begin
                        req_q   <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_fetch_valid) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (i_fetch_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            pc_q     <= RESET_ADDR;
            faddr_q  <= RESET_ADDR;
            skip_q   <= '0;
            win_q    <= '0;
            wvalid_q <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            faddr_q  <= faddr_d;
            skip_q   <= skip_d;
            win_q    <= win_d;
            wvalid_q <= wvalid_d;
            uf_q     <= uf_d;
        end
    end

    // Byte storage is masked by count, so it needs no reset.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_fetch_req    = req_q;
    assign o_fetch_addr   = faddr_q;
    assign o_window       = win_q;
    assign o_window_valid = wvalid_q;
    assign o_pc           = pc_q;
    assign o_underflow    = uf_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: byte-queue scoreboard, consume/fetch
// vector table and hand sequences for flush, drain and reset corners.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic [47:0] window;
    logic        window_valid;
    logic [31:0] pc;
    logic        consume;
    logic [2:0]  consume_len;
    logic        flush;
    logic [31:0] flush_addr;
    logic        underflow;

    always #5 clk = ~clk;

    instr_prefetch_queue dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .o_fetch_req    (fetch_req),
        .o_fetch_addr   (fetch_addr),
        .i_fetch_valid  (fetch_valid),
        .i_fetch_data   (fetch_data),
        .o_window       (window),
        .o_window_valid (window_valid),
        .o_pc           (pc),
        .i_consume      (consume),
        .i_consume_len  (consume_len),
        .i_flush        (flush),
        .i_flush_addr   (flush_addr),
        .o_underflow    (underflow)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  mq[$];
    logic [31:0] mpc;
    logic [31:0] mfa;
    logic [1:0]  mskip;

    typedef struct {
        bit          f;
        logic [31:0] w;
        bit          c;
        logic [2:0]  len;
        bit          ev;
        bit          euf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic bit legal(input logic [2:0] len);
        return (len != 3'd0) && (len <= 3'd6) && (int'(len) <= mq.size());
    endfunction

    task automatic model_pop(input logic [2:0] len);
        repeat (int'(len)) void'(mq.pop_front());
        mpc = mpc + 32'(len);
    endtask

    task automatic model_push(input logic [31:0] d);
        for (int b = int'(mskip); b < 4; b++) mq.push_back(d[8*b +: 8]);
        mskip = 2'd0;
        mfa   = mfa + 32'd4;
    endtask

    task automatic check_model(input string nm);
        logic [47:0] w;
        w = '0;
        for (int i = 0; i < 6; i++)
            if (i < mq.size()) w[8*i +: 8] = mq[i];
        chk({nm, "_window"}, 64'(window), 64'(w));
        chk({nm, "_wvalid"}, 64'(window_valid), 64'(mq.size() >= 6));
        chk({nm, "_pc"}, 64'(pc), 64'(mpc));
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!fetch_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_req_seen"}, 64'(fetch_req), 64'd1);
    endtask

    task automatic fetch(input logic [31:0] d, input logic [2:0] len,
                         input bit cons, input string nm);
        int n;
        bit ok;
        n = 0;
        while (!fetch_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_req) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no request expected request", nm);
            return;
        end
        chk({nm, "_addr"}, 64'(fetch_addr), 64'(mfa));
        fetch_valid = 1'b1;
        fetch_data  = d;
        consume     = cons;
        consume_len = len;
        ok = cons && legal(len);
        @(negedge clk);
        fetch_valid = 1'b0;
        consume     = 1'b0;
        if (ok) model_pop(len);
        model_push(d);
        check_model(nm);
        chk({nm, "_uf"}, 64'(underflow), 64'(cons && !ok));
    endtask

    task automatic consume_op(input logic [2:0] len, input string nm);
        bit ok;
        ok = legal(len);
        consume     = 1'b1;
        consume_len = len;
        @(negedge clk);
        consume = 1'b0;
        if (ok) model_pop(len);
        check_model(nm);
        chk({nm, "_uf"}, 64'(underflow), 64'(!ok));
    endtask

    task automatic do_flush(input logic [31:0] a, input bit with_valid,
                            input string nm);
        flush       = 1'b1;
        flush_addr  = a;
        fetch_valid = with_valid;
        fetch_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        flush       = 1'b0;
        fetch_valid = 1'b0;
        mq.delete();
        mpc   = a;
        mfa   = {a[31:2], 2'b00};
        mskip = a[1:0];
        check_model(nm);
        chk({nm, "_req"}, 64'(fetch_req), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'hBBAA_9988, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 3'd6, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 3'd0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 3'd7, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 32'hFFEE_DDCC, 1'b1, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,         1'b1, 3'd6, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 3'd1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h1312_1110, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'h1716_1514, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 3'd5, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 32'h1B1A_1918, 1'b1, 3'd2, 1'b1, 1'b0};

        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        consume     = 1'b0;
        consume_len = '0;
        flush       = 1'b0;
        flush_addr  = '0;
        mpc   = 32'h0;
        mfa   = 32'h0;
        mskip = 2'd0;

        repeat (2) @(negedge clk);
        chk("rst_req", 64'(fetch_req), 64'd0);
        chk("rst_window", 64'(window), 64'd0);
        chk("rst_wvalid", 64'(window_valid), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_uf", 64'(underflow), 64'd0);
        chk("rst_addr", 64'(fetch_addr), 64'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", 64'(fetch_req), 64'd1);
        fetch(32'h8B04_2400, 3'd0, 1'b0, "w0");
        fetch(32'h0000_0001, 3'd0, 1'b0, "w1");
        chk("boot_window", 64'(window), 64'h0000_0001_8B04_2400);
        chk("boot_pc", 64'(pc), 64'd0);

        fetch(32'h7766_5544, 3'd3, 1'b1, "same_cycle");
        chk("same_cycle_b0", 64'(window[7:0]), 64'h8B);
        chk("same_cycle_pc", 64'(pc), 64'd3);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].f)
                fetch(tbl[i].w, tbl[i].len, tbl[i].c, $sformatf("vec%0d", i));
            else
                consume_op(tbl[i].len, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tv", i), 64'(window_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d_tuf", i), 64'(underflow), 64'(tbl[i].euf));
        end

        do_flush(32'h0000_0100, 1'b0, "flush_idle");
        for (int i = 0; i < 4; i++)
            fetch(wd(32'h100 + 32'(4 * i)), 3'd0, 1'b0, $sformatf("fill%0d", i));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("full_noreq%0d", i), 64'(fetch_req), 64'd0);
        end
        consume_op(3'd6, "drain6");
        chk("drain_noreq", 64'(fetch_req), 64'd0);
        @(negedge clk);
        chk("drain_req", 64'(fetch_req), 64'd1);
        chk("drain_addr", 64'(fetch_addr), 64'h110);
        fetch(wd(32'h110), 3'd0, 1'b0, "refill");
        consume_op(3'd6, "wrap_a");
        consume_op(3'd6, "wrap_b");

        wait_req("pre_drop");
        do_flush(32'h0000_1002, 1'b0, "flush_wait");
        repeat (2) begin
            @(negedge clk);
            chk("drop_noreq", 64'(fetch_req), 64'd0);
        end
        fetch_valid = 1'b1;
        fetch_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        fetch_valid = 1'b0;
        check_model("stale");
        fetch(32'hDDCC_BBAA, 3'd0, 1'b0, "flush_word");
        chk("flush_win16", 64'(window[15:0]), 64'hDDCC);
        chk("flush_pc", 64'(pc), 64'h1002);

        consume_op(3'd4, "uf");
        @(negedge clk);
        chk("uf_once", 64'(underflow), 64'd0);
        check_model("uf_hold");

        wait_req("pre_fv");
        do_flush(32'h0000_2000, 1'b1, "flush_fv");
        fetch(wd(32'h2000), 3'd0, 1'b0, "after_fv");

        wait_req("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 64'(fetch_req), 64'd0);
        chk("arst_window", 64'(window), 64'd0);
        chk("arst_wvalid", 64'(window_valid), 64'd0);
        chk("arst_pc", 64'(pc), 64'd0);
        chk("arst_uf", 64'(underflow), 64'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        fetch_valid = 1'b1;
        fetch_data  = 32'h1234_5678;
        @(negedge clk);
        fetch_valid = 1'b0;
        mq.delete();
        mpc   = 32'h0;
        mfa   = 32'h0;
        mskip = 2'd0;
        check_model("post_rst");
        chk("post_rst_req", 64'(fetch_req), 64'd1);
        chk("post_rst_addr", 64'(fetch_addr), 64'd0);
        fetch(wd(32'h0), 3'd0, 1'b0, "post_rst_fetch");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH_BYTES, default 16, byte capacity of the queue; power of two, at least 8.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset; 4-byte aligned.
REQ-003 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 i_reset  input  1  reset: asynchronous assertion, active-low (0 = reset).
REQ-005 o_fetch_req  output  1  memory word request; held high until accepted.
REQ-006 o_fetch_addr  output  32  word address of the request; bits [1:0] always 0.
REQ-007 i_fetch_valid  input  1  one-cycle pulse; returned word on i_fetch_data.
REQ-008 i_fetch_data  input  32  little-endian instruction word; byte at the lowest address in [7:0].
REQ-009 o_window  output  48  next 6 instruction bytes; byte 0 in [7:0]; unfilled bytes read 0.
REQ-010 o_window_valid  output  1  high when the queue holds at least 6 bytes.
REQ-011 o_pc  output  32  byte address of o_window byte 0.
REQ-012 i_consume  input  1  decoder retires i_consume_len bytes this cycle.
REQ-013 i_consume_len  input  3  bytes retired, 1..6.
REQ-014 i_flush  input  1  redirect to i_flush_addr; takes priority over all other inputs.
REQ-015 i_flush_addr  input  32  new byte address; any alignment allowed.
REQ-016 o_underflow  output  1  one-cycle pulse when a consume is rejected.

Function
REQ-017 The block SHALL implement a FSM with states IDLE (no request outstanding), WAIT (request outstanding) and DROP (a stale response is still due after a flush).
REQ-018 In IDLE, o_fetch_req SHALL rise when count + 4 <= DEPTH_BYTES and no flush is active; the state then moves to WAIT and o_fetch_addr holds until i_fetch_valid.
REQ-019 Only one request SHALL be outstanding; on i_fetch_valid in WAIT, the queue SHALL push 4 bytes, the fetch address SHALL advance by 4 and the state SHALL return to IDLE.
REQ-020 The first word after a flush SHALL have its lowest i_flush_addr[1:0] bytes discarded, so it pushes 4 - skip bytes.
REQ-021 A consume with 1 <= len <= count SHALL pop len bytes and advance o_pc by len.
REQ-022 A consume with len = 0, len > 6 or len > count SHALL be ignored, and o_underflow SHALL pulse on the following cycle.
REQ-023 A push and a consume in the same cycle SHALL both take effect, giving count_next = count + pushed - len; the queue SHALL never overflow, because of REQ-018.
REQ-024 Storage SHALL be circular; read and write pointers SHALL wrap modulo DEPTH_BYTES, and o_window SHALL be assembled across the wrap point.
REQ-025 o_window and o_window_valid SHALL be registered, reflecting the queue state after the most recent edge, with zero combinational paths from inputs.
REQ-026 On i_flush the block SHALL:
- set count to 0;
- load o_pc with i_flush_addr;
- load the fetch address with {i_flush_addr[31:2], 2'b00};
- latch skip = i_flush_addr[1:0].
REQ-027 If i_flush arrives in WAIT, or together with i_fetch_valid, the state SHALL be as follows:
- flush in WAIT without i_fetch_valid: move to DROP;
- in DROP, the next i_fetch_valid SHALL be discarded, then the state moves to IDLE;
- flush in the same cycle as i_fetch_valid: discard that word and move to IDLE.
REQ-028 A flush while already in DROP SHALL stay in DROP and apply the new address.
REQ-029 o_fetch_req SHALL be low in DROP and during the flush cycle.

Reset
REQ-030 While i_reset = 0, outputs SHALL be as follows:
- o_fetch_req = 0, o_window = 0, o_window_valid = 0, o_underflow = 0;
- o_pc = RESET_ADDR, fetch address = RESET_ADDR;
- count = 0, skip = 0, state = IDLE.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request; a response arriving after release while in IDLE SHALL be ignored.
REQ-032 The first o_fetch_req SHALL assert on the first rising edge after i_reset goes to 1.

Verification
REQ-033 Release reset, return 32'h8B04_2400 then 32'h0000_0001 -> requests to 0x0 then 0x4; o_window_valid = 1 with o_window[31:0] = 32'h8B04_2400 and o_window[47:32] = 16'h0001; o_pc = 0.
REQ-034 Queue at 8 bytes, i_consume_len = 3 in the same cycle as i_fetch_valid -> count = 9, o_pc += 3, window byte 0 = old byte 3.
REQ-035 Fill 16 bytes, then consume 6 -> no request while full; request issued once count is 10 or less; o_window stays correct across the pointer wrap.
REQ-036 i_flush with addr 0x1002 in WAIT -> state DROP, stale word discarded, request to 0x1000; the returned 32'hDDCC_BBAA yields o_window[15:0] = 16'hDDCC and o_pc = 0x1002.
REQ-037 Count = 2, consume len = 4 -> queue unchanged, o_underflow pulses once on the following cycle.
REQ-038 Assert i_reset low while a request is outstanding -> all outputs take reset values immediately, asynchronously; after release a stray i_fetch_valid does not change count.
